// File: rtl/seq_pkg.sv
// Shared types and defaults for the note sequencer.
// Optional looped playback is controlled by the LOOP_PLAY_EN macro in note_sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_t;

    localparam int NOTE_W_DEF   = 8;
    localparam int DEPTH_DEF    = 128;
    localparam int TICK_DIV_2HZ = 2500000;

    // Address width of a DEPTH-entry note RAM; a length counter needs one more bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Tick enable generator: one-cycle pulse every TICK_DIV clock cycles.
// Replaces the old derived-clock divider so the whole design stays on one clock.
module tick_gen
    import seq_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_2HZ
) (
    input  logic clk_5MHz,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] STEP = CW'(1);

    logic [CW-1:0] divider;

    always_ff @(posedge clk_5MHz) begin
        if (reset) begin
            divider <= '0;
        end else if (divider == LAST) begin
            divider <= '0;
        end else begin
            divider <= divider + STEP;
        end
    end

    assign tick = (divider == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Tick-paced note recorder/player with erase-last and explicit length tracking.
// Define LOOP_PLAY_EN to make held playback wrap seamlessly to the first note.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int NOTE_W   = NOTE_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int TICK_DIV = TICK_DIV_2HZ
) (
    input  logic                     clk_5MHz,
    input  logic                     reset,
    input  logic                     record_en,
    input  logic                     erase_en,
    input  logic                     play_en,
    input  logic [NOTE_W-1:0]        key_in,
    output logic [NOTE_W-1:0]        note_out,
    output logic                     note_valid,
    output logic                     playing,
    output logic [$clog2(DEPTH):0]   length,
    output logic                     full,
    output logic                     empty,
    output logic                     tick
);

    localparam int            AW      = addr_w(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE     = (AW + 1)'(1);

    state_t              state;
    logic [AW:0]         play_ptr;
    logic [NOTE_W-1:0]   mem [DEPTH];
    logic [NOTE_W-1:0]   rd_data;
    logic [AW-1:0]       rd_addr;
    logic                at_end;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_5MHz (clk_5MHz),
        .reset    (reset),
        .tick     (tick)
    );

    assign full    = (length == DEPTH_L);
    assign empty   = (length == '0);
    assign playing = (state == PLAY);

    // play_ptr == length marks the end of the sequence; the read then points at
    // slot 0 so a looped restart finds mem[0] already fetched.
    assign at_end  = (play_ptr == length);
    assign rd_addr = at_end ? '0 : play_ptr[AW-1:0];

    // NOTE: the note RAM and its read register are deliberately not reset; the
    // length counter alone decides which slots are meaningful.
    always_ff @(posedge clk_5MHz) begin
        if (tick && record_en && !full) begin
            mem[length[AW-1:0]] <= key_in;
        end
        rd_data <= mem[rd_addr];
    end

    // Prefetch is safe: play_ptr and the RAM only change at ticks, and ticks are
    // at least two cycles apart, so rd_data already equals mem[rd_addr] at a tick.
    always_ff @(posedge clk_5MHz) begin
        if (reset) begin
            state      <= IDLE;
            length     <= '0;
            play_ptr   <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
        end else if (tick) begin
            // NOTE: with non-blocking assignments a later assignment in the same
            // block wins, so these defaults describe "not playing this tick".
            note_out   <= '0;
            note_valid <= 1'b0;
            play_ptr   <= '0;
            if (record_en) begin
                state <= RECORD;
                if (!full) begin
                    length <= length + ONE;
                end
            end else if (erase_en) begin
                state <= IDLE;
                if (!empty) begin
                    length <= length - ONE;
                end
            end else if (play_en && state == PLAY && !at_end) begin
                note_out   <= rd_data;
                note_valid <= 1'b1;
                play_ptr   <= play_ptr + ONE;
`ifdef LOOP_PLAY_EN
            end else if (play_en && state == PLAY) begin
                note_out   <= rd_data;
                note_valid <= 1'b1;
                play_ptr   <= ONE;
`endif
            end else if (play_en && state == IDLE && !empty) begin
                state      <= PLAY;
                note_out   <= rd_data;
                note_valid <= 1'b1;
                play_ptr   <= ONE;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
